// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative radix-2 divider family.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_CALC = DIV_CALC,
    ST_DONE = DIV_DONE
  } div_state_e;
endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
// Purely combinational; shared with wider-radix variants that chain several steps per cycle.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);
  logic [WIDTH:0] diff;

  assign diff = rem_shift - {1'b0, divisor};
  assign qbit = ~diff[WIDTH];
  // The partial remainder stays below the divisor, so on a failed trial the top bit is zero.
  assign rem_next = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
endmodule

// File: rtl/div_iter_radix2.sv
// Radix-2 restoring divider, signed/unsigned; result valid WIDTH+1 cycles after accept.
// Single operation in flight; the result is held until out_ready, cancel aborts at any point.
module div_iter_radix2
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             div_cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] x_mag, y_mag, rem_step, q_final;
  logic             sign_s, sign_r, div0, qbit, last_step;

  assign x_mag = (div_signed && x[WIDTH-1]) ? -x : x;
  assign y_mag = (div_signed && y[WIDTH-1]) ? -y : y;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_shift ({rem, dvd[WIDTH-1]}),
    .divisor   (dvs),
    .rem_next  (rem_step),
    .qbit      (qbit)
  );

  // Quotient bits shift into the dividend register as dividend bits shift out.
  assign q_final   = {dvd[WIDTH-2:0], qbit};
  assign last_step = (state == ST_CALC) && (cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_CALC;
      ST_CALC: if (last_step) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (div_cancel) state_nxt = ST_IDLE;
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      sign_s <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      s      <= '0;
      r      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && in_valid) begin
        dvd    <= x_mag;
        dvs    <= y_mag;
        rem    <= '0;
        cnt    <= '0;
        sign_s <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
        sign_r <= div_signed & x[WIDTH-1];
        div0   <= (y == '0);
      end
      if (state == ST_CALC) begin
        dvd <= q_final;
        rem <= rem_step;
        cnt <= last_step ? '0 : cnt + 1'b1;
      end
      if (last_step && !div_cancel) begin
        s <= div0 ? '1 : (sign_s ? -q_final : q_final);
        // A zero divisor leaves rem = |x|, so restoring the dividend sign yields x unchanged.
        r <= sign_r ? -rem_step : rem_step;
      end
    end
  end
endmodule

// File: tb/tb_div_iter_radix2.sv
// Randomized and directed bench for div_iter_radix2 against an arithmetic reference model.
module tb_div_iter_radix2;
  logic        clk = 1'b0;
  logic        reset, div_cancel, in_valid, in_ready, div_signed;
  logic [31:0] x, y, s, r;
  logic        out_valid, out_ready;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_iter_radix2 dut (
    .div_clk    (clk),
    .reset      (reset),
    .div_cancel (div_cancel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .r          (r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Truncating division: quotient rounds toward zero, remainder takes the dividend's sign.
  task automatic model(input logic [31:0] xi, input logic [31:0] yi, input logic sg,
                       output logic [31:0] es, output logic [31:0] er);
    int sx, sy;
    sx = $signed(xi);
    sy = $signed(yi);
    if (yi == 32'd0) begin
      es = 32'hFFFF_FFFF;
      er = xi;
    end else if (sg && sx == 32'sh8000_0000 && sy == -1) begin
      es = xi;
      er = 32'd0;
    end else if (sg) begin
      es = 32'(sx / sy);
      er = 32'(sx % sy);
    end else begin
      es = xi / yi;
      er = xi % yi;
    end
  endtask

  // Called at a negedge with the divider idle; returns at a negedge with the divider idle.
  task automatic run_op(input logic [31:0] xi, input logic [31:0] yi, input logic sg,
                        input int hold, input logic overlap, input string tag);
    logic [31:0] es, er;
    int lat;
    model(xi, yi, sg, es, er);
    chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; x = xi; y = yi; div_signed = sg;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'd33);
    chk({tag, ":s"}, s, es);
    chk({tag, ":r"}, r, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_s"}, s, es);
      chk({tag, ":hold_r"}, r, er);
      chk({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ":hold_out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    in_valid = overlap;
    @(negedge clk);
    chk({tag, ":in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, ":out_valid_after"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected completion", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xi, yi, prev_s, prev_r;
    logic        sg, seen;
    int          a1, k;

    reset = 1'b1; div_cancel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    div_signed = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:s", s, 32'd0);
    chk("rst:r", r, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, "u100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, "s-7_2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "s_ovf");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, "umax_1");
    run_op(32'h1234_5678, 32'd0, 1'b0, 0, 1'b0, "u_div0");
    run_op(32'h1234_5678, 32'd0, 1'b1, 0, 1'b0, "s_div0");
    run_op(32'hF000_0001, 32'd0, 1'b1, 0, 1'b0, "s_div0_neg");
    run_op(32'd1000, 32'hFFFF_FFFD, 1'b1, 10, 1'b0, "hold10");
    run_op(32'd55, 32'd5, 1'b0, 0, 1'b1, "overlap");

    run_op(32'd77, 32'd9, 1'b0, 0, 1'b0, "b2b_a");
    a1 = acc_cyc;
    run_op(32'hFFFF_FF00, 32'd16, 1'b1, 0, 1'b0, "b2b_b");
    chk("b2b:interval", 32'(acc_cyc - a1), 32'd34);
    prev_s = s; prev_r = r;

    // Cancel in cycle T+10.
    in_valid = 1'b1; x = 32'd999; y = 32'd10; div_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    chk("cancel:in_ready", 32'(in_ready), 32'd1);
    chk("cancel:out_valid", 32'(out_valid), 32'd0);
    chk("cancel:s_kept", s, prev_s);
    chk("cancel:r_kept", r, prev_r);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    chk("cancel:no_out_valid", 32'(seen), 32'd0);

    // Reset in cycle T+20.
    in_valid = 1'b1; x = 32'd12345; y = 32'd11; div_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst:in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst:out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst:s", s, 32'd0);
    chk("mid_rst:r", r, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    chk("mid_rst:no_out_valid", 32'(seen), 32'd0);
    run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, "after_abort");

    for (int i = 0; i < 1500; i++) begin
      k  = $urandom_range(0, 9);
      xi = $urandom;
      yi = $urandom;
      sg = 1'($urandom_range(0, 1));
      case (k)
        0: yi = 32'd0;
        1: begin xi = 32'h8000_0000; yi = 32'hFFFF_FFFF; end
        2: yi = 32'($urandom_range(1, 15));
        3: yi = -32'($urandom_range(1, 15));
        4: xi = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(xi, yi, sg, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
